// File: rtl/counter_scheduler.sv
// counter_scheduler
//   Round-robin front end for one shared bit-counter unit. Grants one of
//   N_REQ requesters, captures its operand, launches the unit with a
//   one-cycle init pulse, waits for done and returns the count to the
//   winner with a one-cycle rsp_valid pulse. Only one job is in flight.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, req_data_i   per-client request and operand (client i at [i*WIDTH +: WIDTH])
//   gnt_o               one-hot pulse: operand captured
//   rsp_valid_o         one-hot pulse: rsp_data_o valid for that client
//   rsp_data_o          count result, held until the next response
//   rsp_err_o           qualifies rsp_valid_o: job aborted by timeout
//   busy_o              high in every state except IDLE
//   cnt_init_o          start pulse to the counter unit
//   cnt_operand_o       operand to the counter unit, held until next grant
//   cnt_rst_o           abort pulse to the counter unit
//   cnt_done_i          done pulse from the counter unit
//   cnt_result_i        count from the counter unit, valid with cnt_done_i
//
// Build option
//   COUNTER_SCHED_TIMEOUT_EN : abort a job when WAIT lasts TIMEOUT cycles.
//   Without it, WAIT waits forever and cnt_rst_o / rsp_err_o are tied 0.
//
// state  | meaning
// IDLE   | sample req, pick winner, capture operand
// LAUNCH | cnt_init high for this cycle
// WAIT   | wait for cnt_done (or timeout)
// RESP   | rsp_valid high for the winner for this cycle

module counter_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int CW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [CW-1:0]          rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic                   cnt_init_o,
  output logic [WIDTH-1:0]       cnt_operand_o,
  output logic                   cnt_rst_o,
  input  logic                   cnt_done_i,
  input  logic [CW-1:0]          cnt_result_i
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || CW < $clog2(WIDTH + 1) || TIMEOUT < 2 || TIMEOUT > 256)
  begin : g_param_check
    $error("counter_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    idx_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [CW-1:0]    rsp_data_q;
  logic             busy_q;
  logic             cnt_init_q;
  logic [WIDTH-1:0] cnt_operand_q;

  logic             found_d;
  logic [IW-1:0]    idx_d;
  logic [WIDTH-1:0] operand_d;

  // Search starts one past the last winner, so the previous winner is
  // considered last and every pending client is served within N_REQ jobs.
  always_comb begin
    found_d = 1'b0;
    idx_d   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found_d && req_i[(int'(ptr_q) + k) % N_REQ]) begin
        found_d = 1'b1;
        idx_d   = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign operand_d = req_data_i[int'(idx_d)*WIDTH +: WIDTH];

`ifdef COUNTER_SCHED_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q;
  logic       cnt_rst_q;
  logic       rsp_err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      ptr_q         <= IW'(N_REQ - 1);
      idx_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
      cnt_init_q    <= 1'b0;
      cnt_operand_q <= '0;
`ifdef COUNTER_SCHED_TIMEOUT_EN
      wait_cnt_q    <= '0;
      cnt_rst_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      // pulse outputs default low; each is raised for exactly one cycle
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      cnt_init_q  <= 1'b0;
`ifdef COUNTER_SCHED_TIMEOUT_EN
      cnt_rst_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            idx_q         <= idx_d;
            ptr_q         <= idx_d;
            cnt_operand_q <= operand_d;
            gnt_q         <= N_REQ'(1) << idx_d;
            cnt_init_q    <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef COUNTER_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_done_i) begin
            rsp_data_q  <= cnt_result_i;
            rsp_valid_q <= N_REQ'(1) << idx_q;
            state_q     <= S_RESP;
          end
`ifdef COUNTER_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LAST) begin
            cnt_rst_q   <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= N_REQ'(1) << idx_q;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign busy_o        = busy_q;
  assign cnt_init_o    = cnt_init_q;
  assign cnt_operand_o = cnt_operand_q;

`ifdef COUNTER_SCHED_TIMEOUT_EN
  assign cnt_rst_o = cnt_rst_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign cnt_rst_o = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int CW    = 4;
`ifdef COUNTER_SCHED_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 64;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [CW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic                   cnt_init;
  logic [WIDTH-1:0]       cnt_operand;
  logic                   cnt_rst;
  logic                   cnt_done;
  logic [CW-1:0]          cnt_result;

  always #5 clk = ~clk;

  counter_scheduler #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .CW(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .req_data_i   (req_data),
    .gnt_o        (gnt),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .cnt_init_o   (cnt_init),
    .cnt_operand_o(cnt_operand),
    .cnt_rst_o    (cnt_rst),
    .cnt_done_i   (cnt_done),
    .cnt_result_i (cnt_result)
  );

  // counter unit model: sees init on an edge, raises done lat edges later
  int   lat = 4;
  logic never_done = 1'b0;
  int   cd = 0;

  always @(posedge clk) begin
    if (rst) begin
      cd         <= 0;
      cnt_done   <= 1'b0;
      cnt_result <= '0;
    end else begin
      cnt_done <= 1'b0;
      if (cnt_init) begin
        cd <= lat;
      end else if (cd != 0) begin
        if (cd == 1 && !never_done) begin
          cnt_done   <= 1'b1;
          cnt_result <= CW'($countones(cnt_operand));
        end
        cd <= cd - 1;
      end
    end
  end

  // event logs
  int               cyc = 0;
  logic [N_REQ-1:0] gnt_log[$];
  int               gnt_cyc[$];
  logic [N_REQ-1:0] rsp_log[$];
  logic [CW-1:0]    rsp_dat[$];
  logic             rsp_errq[$];
  int               rsp_cyc[$];
  int               n_init = 0;
  int               n_cntrst = 0;
  int               cntrst_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gnt != '0) begin gnt_log.push_back(gnt); gnt_cyc.push_back(cyc); end
    if (cnt_init) n_init++;
    if (cnt_rst) begin n_cntrst++; cntrst_cyc = cyc; end
    if (rsp_valid != '0) begin
      rsp_log.push_back(rsp_valid);
      rsp_dat.push_back(rsp_data);
      rsp_errq.push_back(rsp_err);
      rsp_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete();
    rsp_log.delete(); rsp_dat.delete(); rsp_errq.delete(); rsp_cyc.delete();
    n_init = 0; n_cntrst = 0; cntrst_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_data = '0; never_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_log.size() < n && k < budget) begin tick(); k++; end
    if (rsp_log.size() < n) check_val("rsp_timeout", rsp_log.size(), n);
  endtask

  task automatic wait_gnt(input int n, input int budget);
    int k = 0;
    while (gnt_log.size() < n && k < budget) begin tick(); k++; end
    if (gnt_log.size() < n) check_val("gnt_timeout", gnt_log.size(), n);
  endtask

  int t0;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // reset state
    repeat (3) tick();
    check_val("reset_outputs",
              {gnt, rsp_valid, rsp_data, rsp_err, busy, cnt_init, cnt_operand, cnt_rst}, 0);
    rst = 1'b0;
    clear_logs();

    // 1: reset mid-WAIT, then single req[2]
    lat = 20;
    req = 4'b0001; req_data[7:0] = 8'h0F;
    tick();
    req = '0;
    repeat (4) tick();
    check_val("t1_busy_in_wait", busy, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t1_rst_outputs",
                {gnt, rsp_valid, rsp_data, rsp_err, busy, cnt_init, cnt_operand, cnt_rst}, 0);
    end
    rst = 1'b0;
    clear_logs();
    repeat (30) tick();
    check_val("t1_no_rsp_after_rst", rsp_log.size(), 0);
    req = 4'b0100; req_data[23:16] = 8'h01;
    tick();
    check_val("t1_gnt_req2", gnt, 4'b0100);
    req = '0;
    wait_rsp(1, 60);

    // 2: single req[1], operand B5, latency 4
    do_reset();
    lat = 4;
    t0 = cyc;
    req = 4'b0010; req_data[15:8] = 8'hB5;
    tick();
    req = '0;
    wait_rsp(1, 40);
    repeat (3) tick();
    check_val("t2_gnt", gnt_log[0], 4'b0010);
    check_val("t2_gnt_lat", gnt_cyc[0] - t0, 1);
    check_val("t2_init_count", n_init, 1);
    check_val("t2_rsp_valid", rsp_log[0], 4'b0010);
    check_val("t2_rsp_data", rsp_dat[0], 5);
    check_val("t2_rsp_lat", rsp_cyc[0] - t0, 7);
    check_val("t2_rsp_err", rsp_errq[0], 0);
    check_val("t2_rsp_data_held", rsp_data, 5);
    check_val("t2_busy_idle", busy, 0);

    // 3: all four requesting continuously
    do_reset();
    lat = 2;
    req = 4'b1111; req_data = 32'h0F07_0301;
    wait_gnt(5, 200);
    req = '0;
    wait_rsp(5, 60);
    repeat (3) tick();
    for (int i = 0; i < 5; i++)
      check_val("t3_grant_order", gnt_log[i], 4'(1) << exp_order[i]);
    check_val("t3_init_per_job", n_init, 5);
    check_val("t3_rsp_count", rsp_log.size(), 5);
    check_val("t3_rsp2_data", rsp_dat[2], 3);
    check_val("t3_rsp4_data", rsp_dat[4], 1);

    // 4: req[3] held, served back-to-back with one IDLE cycle
    do_reset();
    lat = 1;
    req = 4'b1000; req_data[31:24] = 8'hFF;
    wait_gnt(2, 60);
    req = '0;
    wait_rsp(2, 60);
    repeat (3) tick();
    check_val("t4_gnt0", gnt_log[0], 4'b1000);
    check_val("t4_gnt1", gnt_log[1], 4'b1000);
    check_val("t4_idle_gap", gnt_cyc[1] - rsp_cyc[0], 2);
    check_val("t4_rsp_data", rsp_dat[0], 8);

    // 5: req dropped and operand changed after gnt
    do_reset();
    lat = 6;
    req = 4'b0010; req_data[15:8] = 8'hF3;
    tick();
    tick();
    req = '0; req_data[15:8] = 8'h00;
    tick();
    check_val("t5_operand_held", cnt_operand, 8'hF3);
    wait_rsp(1, 40);
    repeat (3) tick();
    check_val("t5_rsp_valid", rsp_log[0], 4'b0010);
    check_val("t5_rsp_data", rsp_dat[0], 6);
    check_val("t5_gnt_count", gnt_log.size(), 1);

`ifdef COUNTER_SCHED_TIMEOUT_EN
    // 6: counter never answers, TIMEOUT=16
    do_reset();
    never_done = 1'b1;
    t0 = cyc;
    req = 4'b0001; req_data[7:0] = 8'hFF;
    tick();
    req = '0;
    wait_rsp(1, 60);
    repeat (3) tick();
    check_val("t6_rsp_err", rsp_errq[0], 1);
    check_val("t6_rsp_data", rsp_dat[0], 0);
    check_val("t6_rsp_valid", rsp_log[0], 4'b0001);
    check_val("t6_rsp_lat", rsp_cyc[0] - t0, 18);
    check_val("t6_cnt_rst_count", n_cntrst, 1);
    check_val("t6_cnt_rst_with_rsp", cntrst_cyc, rsp_cyc[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
